// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
// Captures register-writeback events from the core's debug port into a FIFO of
// timestamped records {stamp, addr, data} and drains them over a valid/ready
// stream. When the FIFO is full and nothing pops, an event is dropped and
// counted, so the core never stalls for tracing.
//
// Optional build macro: TRACE_FILTER_EN
//   defined   - an event is captured only when filter_mask[debug_reg_write_addr]=1
//   undefined - filter_mask is ignored
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   trace_en                  capture enable
//   trace_clear               synchronous flush of FIFO, drop count, overflow flag
//   filter_mask[7:0]          per-register capture mask (TRACE_FILTER_EN only)
//   debug_reg_write_*         writeback strobe / address / data from the core
//   trace_valid/ready/data    head-record stream (first-word fall-through)
//   trace_level               current occupancy, 0..DEPTH
//   trace_overflow            sticky: at least one event dropped
//   trace_drops               saturating dropped-event count
module wb_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 13,
  localparam int AW     = $clog2(DEPTH),
  localparam int REC_W  = STAMP_W + 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trace_en,
  input  logic             trace_clear,
  input  logic [7:0]       filter_mask,
  input  logic             debug_reg_write_enable,
  input  logic [2:0]       debug_reg_write_addr,
  input  logic [15:0]      debug_reg_write_data,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [REC_W-1:0] trace_data,
  output logic [AW:0]      trace_level,
  output logic             trace_overflow,
  output logic [7:0]       trace_drops
);

  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [7:0]         drops_q, drops_d;
  logic               overflow_q, overflow_d;
  logic [REC_W-1:0]   mem_q [DEPTH];

  logic             empty, full, capture, pop, push, drop, mem_we;
  logic [REC_W-1:0] mem_wdata;

`ifdef TRACE_FILTER_EN
  logic filter_pass;
  assign filter_pass = filter_mask[debug_reg_write_addr];
`else
  logic filter_pass;
  logic unused_filter_mask;
  assign filter_pass        = 1'b1;
  assign unused_filter_mask = ^filter_mask;
`endif

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    // Same slot but different lap: the writer is a full lap ahead.
    full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    capture = trace_en && debug_reg_write_enable && filter_pass;
    pop     = !empty && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;

    stamp_d    = stamp_q + STAMP_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drops_d    = drops_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    mem_wdata  = {stamp_q, debug_reg_write_addr, debug_reg_write_data};

    if (trace_clear) begin
      // Clear wins over any coincident push, pop or drop.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drops_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        mem_we   = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drops_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      stamp_q    <= stamp_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drops_q    <= drops_d;
      overflow_q <= overflow_d;
    end
  end

  // Whole array is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= mem_wdata;
    end
  end

  assign trace_valid    = !empty;
  assign trace_data     = mem_q[rd_ptr_q[AW-1:0]];
  assign trace_level    = wr_ptr_q - rd_ptr_q;
  assign trace_overflow = overflow_q;
  assign trace_drops    = drops_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

  localparam int DEPTH   = 16;
  localparam int STAMP_W = 13;
  localparam int AW      = $clog2(DEPTH);
  localparam int REC_W   = STAMP_W + 19;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             trace_en = 1'b0;
  logic             trace_clear = 1'b0;
  logic [7:0]       filter_mask = 8'hFF;
  logic             debug_reg_write_enable = 1'b0;
  logic [2:0]       debug_reg_write_addr = '0;
  logic [15:0]      debug_reg_write_data = '0;
  logic             trace_valid;
  logic             trace_ready = 1'b0;
  logic [REC_W-1:0] trace_data;
  logic [AW:0]      trace_level;
  logic             trace_overflow;
  logic [7:0]       trace_drops;

  wb_trace_buffer #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clk(clk), .rst(rst),
    .trace_en(trace_en), .trace_clear(trace_clear), .filter_mask(filter_mask),
    .debug_reg_write_enable(debug_reg_write_enable),
    .debug_reg_write_addr(debug_reg_write_addr),
    .debug_reg_write_data(debug_reg_write_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .trace_level(trace_level), .trace_overflow(trace_overflow), .trace_drops(trace_drops)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: value seen between edges is the stamp of an event
  // sampled at the next rising edge.
  logic [STAMP_W-1:0] tb_stamp;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_stamp <= '0;
    else     tb_stamp <= tb_stamp + STAMP_W'(1);
  end

  logic [REC_W-1:0] exp_q[$];
  int unsigned m_drops;
  bit          m_ovf;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit passes(input logic [2:0] a);
`ifdef TRACE_FILTER_EN
    return filter_mask[a];
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_now();
    chk("level", 64'(trace_level), 64'(exp_q.size()));
    chk("valid", 64'(trace_valid), 64'(exp_q.size() != 0));
    chk("drops", 64'(trace_drops), 64'(m_drops));
    chk("ovf",   64'(trace_overflow), 64'(m_ovf));
    if (exp_q.size() != 0) chk("data", 64'(trace_data), 64'(exp_q[0]));
  endtask

  // Called between edges: checks current outputs, predicts the next edge,
  // drives the inputs for one rising edge, then returns to idle.
  task automatic cyc(input bit ev, input logic [2:0] a, input logic [15:0] d,
                     input bit rdy, input bit clr);
    bit pop, acc;
    int sz;
    check_now();
    sz  = exp_q.size();
    pop = rdy && (sz != 0);
    acc = ev && passes(a);
    if (clr) begin
      exp_q.delete();
      m_drops = 0;
      m_ovf   = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        if (sz < DEPTH || pop) exp_q.push_back({tb_stamp, a, d});
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
    trace_en               = ev;
    debug_reg_write_enable = ev;
    debug_reg_write_addr   = a;
    debug_reg_write_data   = d;
    trace_ready            = rdy;
    trace_clear            = clr;
    @(negedge clk);
    trace_en               = 1'b0;
    debug_reg_write_enable = 1'b0;
    trace_ready            = 1'b0;
    trace_clear            = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    m_drops = 0;
    m_ovf   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", 64'(trace_data), 64'h0);
    rst = 1'b0;

    // Reset state, then single capture at stamp 5.
    idle(5);
    cyc(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0);
    chk("single_rec", 64'(trace_data), 64'({13'd5, 3'd3, 16'h1234}));
    chk("single_lvl", 64'(trace_level), 64'd1);
    idle(2);
    drain();

    // Fill and overflow, then push+pop while full.
    for (int i = 0; i < 19; i++) cyc(1'b1, 3'(i), 16'(16'hA000 + i), 1'b0, 1'b0);
    chk("fill_lvl", 64'(trace_level), 64'd16);
    chk("fill_drops", 64'(trace_drops), 64'd3);
    chk("fill_ovf", 64'(trace_overflow), 64'd1);
    cyc(1'b1, 3'd7, 16'hBEEF, 1'b1, 1'b0);
    chk("full_pp_lvl", 64'(trace_level), 64'd16);
    chk("full_pp_drops", 64'(trace_drops), 64'd3);
    drain();

    // Clear with coincident event and pop.
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'd1, 16'(16'hC000 + i), 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 16'hDEAD, 1'b1, 1'b1);
    chk("clr_lvl", 64'(trace_level), 64'd0);
    chk("clr_valid", 64'(trace_valid), 64'd0);
    cyc(1'b1, 3'd4, 16'h5555, 1'b0, 1'b0);
    drain();

    // Stamp wrap.
    for (int g = 0; g < 9000 && tb_stamp != 13'h1FFF; g++) idle(1);
    cyc(1'b1, 3'd5, 16'h0F0F, 1'b0, 1'b0);
    cyc(1'b1, 3'd6, 16'hF0F0, 1'b0, 1'b0);
    chk("wrap_a", 64'(trace_data), 64'({13'h1FFF, 3'd5, 16'h0F0F}));
    drain();

    // Drop-count saturation.
    for (int i = 0; i < DEPTH + 300; i++) cyc(1'b1, 3'(i), 16'(i), 1'b0, 1'b0);
    chk("sat_drops", 64'(trace_drops), 64'd255);
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);

    // Filter.
    filter_mask = 8'h04;
    cyc(1'b1, 3'd1, 16'h0111, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 16'h0222, 1'b0, 1'b0);
    cyc(1'b1, 3'd3, 16'h0333, 1'b0, 1'b0);
`ifdef TRACE_FILTER_EN
    chk("filt_lvl", 64'(trace_level), 64'd1);
`else
    chk("filt_lvl", 64'(trace_level), 64'd3);
`endif
    drain();
    filter_mask = 8'hFF;

    // Asynchronous reset mid-operation.
    cyc(1'b1, 3'd1, 16'h7777, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 16'h8888, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
    check_now();
    chk("arst_data", 64'(trace_data), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
